spi_master_ctrl: RTL and testbench
==================================

Name: spi_master_ctrl

Overview:
- Sequences the SoC's SPI pins (spi_clk, spi_mosi, spi_miso, spi_CE) for one external slave.
- Takes byte commands on a valid/ready interface and runs a mode-0 (CPOL=0, CPHA=0), MSB-first full-duplex byte transfer.
- Returns the received byte on a one-cycle response strobe.
- Holds chip-enable low across a multi-byte burst until a command flagged "last" completes. Sits between the bus-side SPI register block and the pads.

Parameters:
- CLK_DIV, 4: clk cycles per spi_clk half-period. Legal range is 1..255; the divider counter is $clog2(CLK_DIV+1) bits wide.
- DATA_W, 8: bits per transfer. Only 8 is verified.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller accepts a command this cycle; high only in IDLE
- cmd_data  in  DATA_W  byte to transmit
- cmd_last  in  1  deassert spi_CE after this byte
- rsp_valid  out  1  one-cycle strobe, received byte valid
- rsp_data  out  DATA_W  received byte; holds until the next strobe
- busy  out  1  high whenever the state is not IDLE
- spi_clk  out  1  serial clock; idles low
- spi_mosi  out  1  serial data out
- spi_miso  in  1  serial data in
- spi_CE  out  1  chip enable, active-low

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, spi_CE=1, spi_clk=0, spi_mosi=0, rsp_valid=0, rsp_data=0, busy=0, divider=0, bit counter=0.
- Accept rule: a command is accepted on a clk edge where cmd_valid & cmd_ready. cmd_data and cmd_last are latched into the shift register and the last flag. cmd_valid outside IDLE is ignored; no command is lost, because the requester holds it until accepted.
- SETUP state (only if spi_CE=1 at accept): spi_CE=0, spi_clk=0, spi_mosi=shift[7], lasts CLK_DIV cycles.
- If spi_CE is already 0 at accept (burst continuation), go directly to LOW.
- LOW state: spi_clk=0, spi_mosi=shift[7], lasts CLK_DIV cycles. On exit, sample spi_miso into the receive register (LSB in, shift left). This exit edge is the spi_clk rising edge.
- HIGH state: spi_clk=1, lasts CLK_DIV cycles. On exit, shift the transmit register left by 1 and increment the bit counter. If 8 bits are done, go to DONE; otherwise go to LOW.
- DONE state (1 cycle): rsp_valid=1, rsp_data=received byte, spi_clk=0. Next state is HOLD if the last flag is set, otherwise IDLE with spi_CE still 0.
- HOLD state: spi_CE=0, spi_clk=0, lasts CLK_DIV cycles. Then GAP.
- GAP state: spi_CE=1, lasts CLK_DIV cycles (minimum CE-high time). Then IDLE.
- spi_mosi is 0 in IDLE, DONE, HOLD and GAP.
- Latency, accept at cycle 0:
  - From CE high: spi_CE=0 at cycle 1; rsp_valid at cycle 1+17*CLK_DIV.
  - From CE low: rsp_valid at cycle 1+16*CLK_DIV.
- Exactly 8 spi_clk rising edges occur per byte.
- rsp_valid has no backpressure. A missed strobe is lost, but rsp_data remains readable.
- rst asserted in any state: the next cycle shows reset values. No rsp_valid for the aborted byte, and spi_CE rises immediately.

Test Plan:
- Single byte, CLK_DIV=4, miso looped to mosi, cmd_data=0xA5, last=1, accepted at cycle 0 -> spi_CE=0 at cycle 1; 8 rising edges; rsp_valid at cycle 69 with rsp_data=0xA5; spi_CE=1 at cycle 74; cmd_ready=1 at cycle 78.
- Burst 0x01, 0x80, 0xFF with last only on the third, miso tied 1 -> spi_CE low continuously from the first accept to HOLD end; each rsp_data=0xFF; second and third rsp_valid arrive 65 cycles after their accepts; mosi bit order MSB first matches each byte.
- mosi=0xFF, miso tied 0 -> rsp_data=0x00; mosi=0x00 with miso toggling at each rising edge starting 1 -> rsp_data=0xAA.
- rst pulsed at cycle 30 of a transfer -> cycle 31: spi_CE=1, spi_clk=0, busy=0, no rsp_valid; a following command 0x3C (loopback) completes with rsp_data=0x3C.
- cmd_valid held high while busy, cmd_data changed mid-transfer -> only one accept per IDLE visit; the in-flight byte is unaffected.
- CLK_DIV=1, 0x5A loopback -> spi_clk period 2 cycles; rsp_valid at cycle 18, rsp_data=0x5A.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one byte per command, MSB first, full duplex.
// Chip enable stays low across a burst until a command flagged last completes.
`timescale 1ns / 1ps
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_last,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_CE
);

  localparam int unsigned DivW = $clog2(CLK_DIV + 1);
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] BitsLast = CntW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StHigh,
    StDone,
    StHold,
    StGap
  } state_e;

  state_e state_q, state_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [CntW-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              last_q, last_d;
  logic              ce_q, ce_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              div_end;

  assign div_end = (div_q == DivLast);

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    last_d      = last_q;
    ce_d        = ce_q;

    // Every timed phase runs CLK_DIV cycles and restarts the divider on exit.
    if (state_q inside {StSetup, StLow, StHigh, StHold, StGap}) begin
      div_d = div_end ? '0 : div_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          tx_d    = cmd_data;
          last_d  = cmd_last;
          bit_d   = '0;
          div_d   = '0;
          ce_d    = 1'b0;
          state_d = ce_q ? StSetup : StLow;
        end
      end
      StSetup: begin
        if (div_end) state_d = StLow;
      end
      StLow: begin
        if (div_end) begin
          rx_d    = {rx_q[DATA_W-2:0], spi_miso};
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (div_end) begin
          tx_d  = {tx_q[DATA_W-2:0], 1'b0};
          bit_d = bit_q + 1'b1;
          if (bit_q == BitsLast) begin
            rsp_data_d = rx_q;
            state_d    = StDone;
          end else begin
            state_d = StLow;
          end
        end
      end
      StDone: begin
        state_d = last_q ? StHold : StIdle;
      end
      StHold: begin
        if (div_end) begin
          ce_d    = 1'b1;
          state_d = StGap;
        end
      end
      StGap: begin
        if (div_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Pad outputs are registered from the next state so they never glitch.
    sclk_d      = (state_d == StHigh);
    mosi_d      = (state_d inside {StSetup, StLow, StHigh}) ? tx_d[DATA_W-1] : 1'b0;
    rsp_valid_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rsp_data_q  <= '0;
      last_q      <= 1'b0;
      ce_q        <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      last_q      <= last_d;
      ce_q        <= ce_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_CE    = ce_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: cycle-by-cycle comparison against a timing model
// derived from the phase lengths, plus a CLK_DIV=1 instance for the fast corner.
`timescale 1ns / 1ps
module tb_spi_master_ctrl;

  localparam int K = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] cmd_data = 8'h00;
  logic       cmd_last = 1'b0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_CE;
  logic       loop_en = 1'b0;
  logic       miso_drv = 1'b0;

  logic       cmd_valid1 = 1'b0;
  logic       cmd_ready1;
  logic [7:0] cmd_data1 = 8'h00;
  logic       cmd_last1 = 1'b0;
  logic       rsp_valid1;
  logic [7:0] rsp_data1;
  logic       busy1;
  logic       spi_clk1;
  logic       spi_mosi1;
  logic       spi_CE1;

  int n_checks = 0;
  int n_fail = 0;
  logic ce_model = 1'b1;

  assign spi_miso = loop_en ? spi_mosi : miso_drv;

  always #5 clk = ~clk;

  spi_master_ctrl #(.CLK_DIV(K), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_data (cmd_data),
    .cmd_last (cmd_last),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .spi_clk  (spi_clk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_CE   (spi_CE)
  );

  spi_master_ctrl #(.CLK_DIV(1), .DATA_W(8)) dut_fast (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid1),
    .cmd_ready(cmd_ready1),
    .cmd_data (cmd_data1),
    .cmd_last (cmd_last1),
    .rsp_valid(rsp_valid1),
    .rsp_data (rsp_data1),
    .busy     (busy1),
    .spi_clk  (spi_clk1),
    .spi_mosi (spi_mosi1),
    .spi_miso (spi_mosi1),
    .spi_CE   (spi_CE1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // One byte transfer. Entered and left at a negedge. abort_at>0 pulses rst in that cycle.
  task automatic xfer(input logic [7:0] data, input logic last, input logic [7:0] miso_byte,
                      input logic loop, input logic hold_valid, input int abort_at);
    int n, s, d_cyc, end_cyc, p;
    logic [7:0] exp_rx;
    logic exp_ce, exp_clk, exp_mosi, exp_rv, exp_busy;
    n = 0;
    while (!cmd_ready) begin
      if (n == 300) begin
        check_eq("ready_timeout", 32'(cmd_ready), 32'd1);
        return;
      end
      @(negedge clk);
      n++;
    end
    check_eq("ce_at_accept", 32'(spi_CE), 32'(ce_model));
    loop_en   = loop;
    exp_rx    = loop ? data : miso_byte;
    cmd_valid = 1'b1;
    cmd_data  = data;
    cmd_last  = last;
    s         = ce_model ? K : 0;
    d_cyc     = s + 16 * K + 1;
    end_cyc   = last ? d_cyc + 2 * K + 1 : d_cyc + 1;
    for (int c = 1; c <= end_cyc; c++) begin
      @(negedge clk);
      if (hold_valid) begin
        cmd_data = 8'($urandom);
        cmd_last = 1'($urandom);
        if (c == d_cyc) cmd_valid = 1'b0;
      end else begin
        cmd_valid = 1'b0;
      end
      exp_ce = 1'b0; exp_clk = 1'b0; exp_mosi = 1'b0; exp_rv = 1'b0; exp_busy = 1'b1;
      p = 0;
      if (c <= s) begin
        exp_mosi = data[7];
      end else if (c < d_cyc) begin
        p        = (c - s - 1) / K;
        exp_clk  = 1'(p % 2);
        exp_mosi = data[7 - p / 2];
        if (p % 2 == 0) miso_drv = miso_byte[7 - p / 2];
      end else if (c == d_cyc) begin
        exp_rv = 1'b1;
      end else if (!last) begin
        exp_busy = 1'b0;
      end else if (c > d_cyc + K) begin
        exp_ce   = 1'b1;
        exp_busy = (c <= d_cyc + 2 * K);
      end
      check_eq("spi_CE", 32'(spi_CE), 32'(exp_ce));
      check_eq("spi_clk", 32'(spi_clk), 32'(exp_clk));
      check_eq("spi_mosi", 32'(spi_mosi), 32'(exp_mosi));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check_eq("busy", 32'(busy), 32'(exp_busy));
      check_eq("cmd_ready", 32'(cmd_ready), 32'(!exp_busy));
      if (exp_rv) check_eq("rsp_data", 32'(rsp_data), 32'(exp_rx));
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_ce", 32'(spi_CE), 32'd1);
        check_eq("rst_clk", 32'(spi_clk), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_mosi", 32'(spi_mosi), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst      = 1'b0;
        ce_model = 1'b1;
        return;
      end
    end
    check_eq("rsp_data_hold", 32'(rsp_data), 32'(exp_rx));
    ce_model = last;
  endtask

  task automatic fast_test();
    int rises, first, lastr, rv_cyc;
    logic prev;
    logic [7:0] rv_data;
    rises = 0; first = 0; lastr = 0; rv_cyc = 0; prev = 1'b0; rv_data = 8'h00;
    check_eq("fast_ready", 32'(cmd_ready1), 32'd1);
    cmd_valid1 = 1'b1;
    cmd_data1  = 8'h5A;
    cmd_last1  = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      cmd_valid1 = 1'b0;
      if (spi_clk1 && !prev) begin
        rises++;
        if (first == 0) first = c;
        lastr = c;
      end
      prev = spi_clk1;
      if (rsp_valid1 && rv_cyc == 0) begin
        rv_cyc  = c;
        rv_data = rsp_data1;
      end
    end
    check_eq("fast_rsp_cycle", 32'(rv_cyc), 32'd18);
    check_eq("fast_rsp_data", 32'(rv_data), 32'h5A);
    check_eq("fast_rises", 32'(rises), 32'd8);
    check_eq("fast_first_rise", 32'(first), 32'd3);
    check_eq("fast_last_rise", 32'(lastr), 32'd17);
    check_eq("fast_ce_end", 32'(spi_CE1), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_ce", 32'(spi_CE), 32'd1);
    check_eq("reset_clk", 32'(spi_clk), 32'd0);
    check_eq("reset_mosi", 32'(spi_mosi), 32'd0);
    check_eq("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", 32'(cmd_ready), 32'd1);

    xfer(8'hA5, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    xfer(8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
    xfer(8'h80, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
    xfer(8'hFF, 1'b1, 8'hFF, 1'b0, 1'b0, 0);
    xfer(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, 0);
    xfer(8'h00, 1'b1, 8'hAA, 1'b0, 1'b0, 0);
    xfer(8'h96, 1'b1, 8'h00, 1'b1, 1'b0, 30);
    xfer(8'h3C, 1'b1, 8'h00, 1'b1, 1'b0, 0);
    xfer(8'hC3, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    xfer(8'h69, 1'b1, 8'h00, 1'b1, 1'b1, 0);
    for (int i = 0; i < 30; i++) begin
      xfer(8'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom), 1'($urandom), 1'($urandom),
           0);
    end
    xfer(8'h42, 1'b1, 8'h00, 1'b1, 1'b0, 0);

    fast_test();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
